// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch interlocks, operand forwarding,
// data-memory wait tracking with a sticky timeout, and a saturating stall counter.
module hazard_ctrl #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       rs1_addr_d_i,
   input  logic [4:0]       rs2_addr_d_i,
   input  logic [4:0]       rs1_addr_e_i,
   input  logic [4:0]       rs2_addr_e_i,
   input  logic [4:0]       wr_addr_e_i,
   input  logic             result_src_e_i,
   input  logic             pc_src_e_i,
   input  logic [4:0]       wr_addr_m_i,
   input  logic             reg_wr_en_m_i,
   input  logic [4:0]       wr_addr_w_i,
   input  logic             reg_wr_en_w_i,
   input  logic             mem_req_m_i,
   input  logic             mem_ready_i,
   output logic             stall_f_o,
   output logic             stall_d_o,
   output logic             stall_e_o,
   output logic             stall_m_o,
   output logic             flush_d_o,
   output logic             flush_e_o,
   output logic             flush_w_o,
   output logic [1:0]       forward_a_e_o,
   output logic [1:0]       forward_b_e_o,
   output logic             mem_busy_o,
   output logic             mem_timeout_o,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic [1:0]       state_dbg_o
);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_WAIT = 2'b01;
   localparam logic [1:0] ST_ERR  = 2'b10;
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]       state_q;
   logic [7:0]       wait_cnt_q;
   logic             timeout_q;
   logic [CNT_W-1:0] stall_cnt_q;
   logic             mem_stall;
   logic             lw_stall;
   logic             any_stall;

   // Memory handshake: an access in M is outstanding on every cycle where
   // mem_req_m_i is high and mem_ready_i is low; the cycle mem_ready_i is high
   // completes it and the pipeline advances.
   assign mem_stall = mem_req_m_i & ~mem_ready_i;

   assign lw_stall = result_src_e_i & (wr_addr_e_i != 5'd0) &
                     ((wr_addr_e_i == rs1_addr_d_i) | (wr_addr_e_i == rs2_addr_d_i)) &
                     ~pc_src_e_i;

   always_comb begin
      stall_f_o     = 1'b0;
      stall_d_o     = 1'b0;
      stall_e_o     = 1'b0;
      stall_m_o     = 1'b0;
      flush_d_o     = 1'b0;
      flush_e_o     = 1'b0;
      flush_w_o     = 1'b0;
      forward_a_e_o = 2'b00;
      forward_b_e_o = 2'b00;
      if (rst_i) begin
         flush_d_o = 1'b1;
         flush_e_o = 1'b1;
         flush_w_o = 1'b1;
      end else begin
         if (reg_wr_en_m_i && wr_addr_m_i == rs1_addr_e_i && rs1_addr_e_i != 5'd0)
            forward_a_e_o = 2'b10;
         else if (reg_wr_en_w_i && wr_addr_w_i == rs1_addr_e_i && rs1_addr_e_i != 5'd0)
            forward_a_e_o = 2'b01;
         if (reg_wr_en_m_i && wr_addr_m_i == rs2_addr_e_i && rs2_addr_e_i != 5'd0)
            forward_b_e_o = 2'b10;
         else if (reg_wr_en_w_i && wr_addr_w_i == rs2_addr_e_i && rs2_addr_e_i != 5'd0)
            forward_b_e_o = 2'b01;
         // Memory stall freezes the whole pipe; any redirect waits until it clears.
         if (state_q == ST_ERR || mem_stall) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            stall_e_o = 1'b1;
            stall_m_o = 1'b1;
            flush_w_o = 1'b1;
         end else if (pc_src_e_i) begin
            flush_d_o = 1'b1;
            flush_e_o = 1'b1;
         end else if (lw_stall) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            flush_e_o = 1'b1;
         end
      end
   end

   assign any_stall = stall_f_o | stall_d_o | stall_e_o | stall_m_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         wait_cnt_q  <= 8'd0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               wait_cnt_q <= 8'd0;
               if (mem_stall) state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (mem_ready_i) begin
                  state_q    <= ST_IDLE;
                  wait_cnt_q <= 8'd0;
               end else if (wait_cnt_q == WAIT_LAST) begin
                  state_q   <= ST_ERR;
                  timeout_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
            end
            ST_ERR:  state_q <= ST_ERR;
            default: state_q <= ST_IDLE;
         endcase
         if (any_stall && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign mem_busy_o     = (state_q == ST_WAIT);
   assign mem_timeout_o  = timeout_q;
   assign stall_cycles_o = stall_cnt_q;
   assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (TIMEOUT=4, 4-bit stall counter to reach saturation).
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, wr_e, wr_m, wr_w;
   logic       res_src_e, pc_src, wen_m, wen_w, mem_req, mem_rdy;
   logic       st_f, st_d, st_e, st_m, fl_d, fl_e, fl_w, busy, tmo;
   logic [1:0] fwd_a, fwd_b, state;
   logic [3:0] scnt;
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .rs1_addr_d_i(rs1_d), .rs2_addr_d_i(rs2_d),
      .rs1_addr_e_i(rs1_e), .rs2_addr_e_i(rs2_e),
      .wr_addr_e_i(wr_e), .result_src_e_i(res_src_e), .pc_src_e_i(pc_src),
      .wr_addr_m_i(wr_m), .reg_wr_en_m_i(wen_m),
      .wr_addr_w_i(wr_w), .reg_wr_en_w_i(wen_w),
      .mem_req_m_i(mem_req), .mem_ready_i(mem_rdy),
      .stall_f_o(st_f), .stall_d_o(st_d), .stall_e_o(st_e), .stall_m_o(st_m),
      .flush_d_o(fl_d), .flush_e_o(fl_e), .flush_w_o(fl_w),
      .forward_a_e_o(fwd_a), .forward_b_e_o(fwd_b),
      .mem_busy_o(busy), .mem_timeout_o(tmo), .stall_cycles_o(scnt),
      .state_dbg_o(state)
   );

   // Inputs change just after the falling edge; outputs are sampled 1 ns later.
   task automatic idle_inputs();
      rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
      wr_e = 5'd0; wr_m = 5'd0; wr_w = 5'd0;
      res_src_e = 1'b0; pc_src = 1'b0; wen_m = 1'b0; wen_w = 1'b0;
      mem_req = 1'b0; mem_rdy = 1'b0;
   endtask

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b1; mem_req = 1'b1; wen_m = 1'b1; wr_m = 5'd3; rs1_e = 5'd3;
      #1;
      n_cmp++; if ({st_f, st_d, st_e, st_m} !== 4'b0000) begin n_err++; $display("FAIL rst_stalls got=%b exp=0000", {st_f, st_d, st_e, st_m}); end
      n_cmp++; if ({fl_d, fl_e, fl_w} !== 3'b111) begin n_err++; $display("FAIL rst_flushes got=%b exp=111", {fl_d, fl_e, fl_w}); end
      n_cmp++; if (fwd_a !== 2'b00) begin n_err++; $display("FAIL rst_fwd_a got=%b exp=00", fwd_a); end
      @(negedge clk);
      idle_inputs();
      rst = 1'b0;
      #1;
      n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL rst_state got=%b exp=00", state); end
      n_cmp++; if ({busy, tmo} !== 2'b00) begin n_err++; $display("FAIL rst_busy_tmo got=%b exp=00", {busy, tmo}); end
      n_cmp++; if (scnt !== 4'd0) begin n_err++; $display("FAIL rst_scnt got=%0d exp=0", scnt); end
      n_cmp++; if ({st_f, st_d, st_e, st_m, fl_d, fl_e, fl_w} !== 7'd0) begin n_err++; $display("FAIL rst_idle_outs got=%b exp=0000000", {st_f, st_d, st_e, st_m, fl_d, fl_e, fl_w}); end
   endtask

   task automatic test_load_use();
      @(negedge clk);
      res_src_e = 1'b1; wr_e = 5'd5; rs1_d = 5'd5; rs2_d = 5'd1;
      #1;
      n_cmp++; if ({st_f, st_d, fl_e} !== 3'b111) begin n_err++; $display("FAIL lu_stall got=%b exp=111", {st_f, st_d, fl_e}); end
      n_cmp++; if ({st_e, st_m, fl_d, fl_w} !== 4'b0000) begin n_err++; $display("FAIL lu_others got=%b exp=0000", {st_e, st_m, fl_d, fl_w}); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_cmp++; if ({st_f, st_d, fl_e} !== 3'b000) begin n_err++; $display("FAIL lu_release got=%b exp=000", {st_f, st_d, fl_e}); end
      n_cmp++; if (scnt !== 4'd1) begin n_err++; $display("FAIL lu_scnt got=%0d exp=1", scnt); end
   endtask

   task automatic test_forwarding();
      @(negedge clk);
      wen_m = 1'b1; wr_m = 5'd7; wen_w = 1'b1; wr_w = 5'd7; rs2_e = 5'd7; rs1_e = 5'd3;
      #1;
      n_cmp++; if (fwd_b !== 2'b10) begin n_err++; $display("FAIL fwd_b_m_prio got=%b exp=10", fwd_b); end
      n_cmp++; if (fwd_a !== 2'b00) begin n_err++; $display("FAIL fwd_a_nomatch got=%b exp=00", fwd_a); end
      wen_m = 1'b0; rs1_e = 5'd7;
      #1;
      n_cmp++; if ({fwd_a, fwd_b} !== 4'b0101) begin n_err++; $display("FAIL fwd_w_only got=%b exp=0101", {fwd_a, fwd_b}); end
      wen_m = 1'b1; wr_m = 5'd0; wr_w = 5'd0; rs2_e = 5'd0; rs1_e = 5'd0;
      #1;
      n_cmp++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_err++; $display("FAIL fwd_x0 got=%b exp=0000", {fwd_a, fwd_b}); end
      wen_m = 1'b1; wr_m = 5'd12; wen_w = 1'b1; wr_w = 5'd20; rs1_e = 5'd20; rs2_e = 5'd12;
      #1;
      n_cmp++; if ({fwd_a, fwd_b} !== 4'b0110) begin n_err++; $display("FAIL fwd_mixed got=%b exp=0110", {fwd_a, fwd_b}); end
      idle_inputs();
   endtask

   task automatic test_branch_load_use();
      @(negedge clk);
      res_src_e = 1'b1; wr_e = 5'd5; rs1_d = 5'd5; pc_src = 1'b1;
      #1;
      n_cmp++; if ({fl_d, fl_e} !== 2'b11) begin n_err++; $display("FAIL br_flush got=%b exp=11", {fl_d, fl_e}); end
      n_cmp++; if ({st_f, st_d} !== 2'b00) begin n_err++; $display("FAIL br_no_stall got=%b exp=00", {st_f, st_d}); end
      next_cycle();
      idle_inputs();
      #1;
      n_cmp++; if (scnt !== 4'd1) begin n_err++; $display("FAIL br_scnt got=%0d exp=1", scnt); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      res_src_e = 1'b1; wr_e = 5'd9; rs2_d = 5'd9; rs1_d = 5'd2;
      #1;
      n_cmp++; if ({st_f, st_d, fl_e} !== 3'b111) begin n_err++; $display("FAIL b2b_rs2 got=%b exp=111", {st_f, st_d, fl_e}); end
      @(negedge clk);
      wr_e = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0;
      #1;
      n_cmp++; if ({st_f, st_d, fl_e} !== 3'b000) begin n_err++; $display("FAIL b2b_x0 got=%b exp=000", {st_f, st_d, fl_e}); end
      @(negedge clk);
      res_src_e = 1'b0; wr_e = 5'd4; rs1_d = 5'd4;
      #1;
      n_cmp++; if ({st_f, st_d, fl_e} !== 3'b000) begin n_err++; $display("FAIL b2b_not_load got=%b exp=000", {st_f, st_d, fl_e}); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_cmp++; if (scnt !== 4'd2) begin n_err++; $display("FAIL b2b_scnt got=%0d exp=2", scnt); end
   endtask

   task automatic test_mem_wait();
      @(negedge clk);
      mem_req = 1'b1; mem_rdy = 1'b0; pc_src = 1'b1;
      #1;
      n_cmp++; if ({st_f, st_d, st_e, st_m, fl_w} !== 5'b11111) begin n_err++; $display("FAIL mw_c0_stalls got=%b exp=11111", {st_f, st_d, st_e, st_m, fl_w}); end
      n_cmp++; if ({fl_d, fl_e, busy} !== 3'b000) begin n_err++; $display("FAIL mw_c0_defer got=%b exp=000", {fl_d, fl_e, busy}); end
      for (int i = 1; i < 3; i++) begin
         next_cycle();
         n_cmp++; if ({st_f, st_d, st_e, st_m, fl_w, busy} !== 6'b111111) begin n_err++; $display("FAIL mw_wait%0d got=%b exp=111111", i, {st_f, st_d, st_e, st_m, fl_w, busy}); end
      end
      @(negedge clk);
      mem_rdy = 1'b1;
      #1;
      n_cmp++; if ({st_f, st_d, st_e, st_m, fl_w} !== 5'b00000) begin n_err++; $display("FAIL mw_ready_release got=%b exp=00000", {st_f, st_d, st_e, st_m, fl_w}); end
      n_cmp++; if ({fl_d, fl_e, busy} !== 3'b111) begin n_err++; $display("FAIL mw_ready_redirect got=%b exp=111", {fl_d, fl_e, busy}); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_cmp++; if ({state, busy} !== 3'b000) begin n_err++; $display("FAIL mw_back_idle got=%b exp=000", {state, busy}); end
      n_cmp++; if (scnt !== 4'd5) begin n_err++; $display("FAIL mw_scnt got=%0d exp=5", scnt); end
   endtask

   task automatic test_timeout();
      @(negedge clk);
      mem_req = 1'b1; mem_rdy = 1'b0;
      for (int i = 0; i < 4; i++) next_cycle();
      n_cmp++; if ({state, tmo} !== 3'b010) begin n_err++; $display("FAIL to_last_wait got=%b exp=010", {state, tmo}); end
      next_cycle();
      n_cmp++; if ({state, tmo, busy} !== 4'b1010) begin n_err++; $display("FAIL to_err got=%b exp=1010", {state, tmo, busy}); end
      mem_req = 1'b0;
      #1;
      n_cmp++; if ({st_f, st_d, st_e, st_m} !== 4'b1111) begin n_err++; $display("FAIL to_err_stalls got=%b exp=1111", {st_f, st_d, st_e, st_m}); end
      for (int i = 0; i < 6; i++) next_cycle();
      n_cmp++; if ({state, tmo} !== 3'b101) begin n_err++; $display("FAIL to_err_sticky got=%b exp=101", {state, tmo}); end
      n_cmp++; if (scnt !== 4'd15) begin n_err++; $display("FAIL to_scnt_sat got=%0d exp=15", scnt); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if ({state, tmo, busy} !== 4'b0000) begin n_err++; $display("FAIL to_rst_state got=%b exp=0000", {state, tmo, busy}); end
      n_cmp++; if (scnt !== 4'd0) begin n_err++; $display("FAIL to_rst_scnt got=%0d exp=0", scnt); end
      n_cmp++; if ({st_f, st_d, st_e, st_m} !== 4'b0000) begin n_err++; $display("FAIL to_rst_stalls got=%b exp=0000", {st_f, st_d, st_e, st_m}); end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_load_use();
      test_forwarding();
      test_branch_load_use();
      test_back_to_back();
      test_mem_wait();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
